// File: rtl/fetch_steer.sv
// fetch_steer: instruction-fetch and branch-steering controller for the PC.
// Fetches one instruction per pass, hands it to the datapath, and pulses the
// decoded branch type to the PC for a single cycle. Outside that cycle the
// branch type is held at 2'b11 so the PC does not move.
// Optional build macro: FETCH_STEER_STATS_EN adds the stat_retired and
// stat_taken 16-bit saturating counters.
module fetch_steer #(
    parameter int IW = 9,
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     p_ct,
    output logic              pc_rst,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_valid,
    input  logic [IW-1:0]     imem_data,
    output logic [IW-1:0]     inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              zero_flag,
    output logic [1:0]        branchType,
    output logic signed [2:0] threeBitOffset,
    output logic signed [5:0] sixBitOffset,
    output logic              halted
`ifdef FETCH_STEER_STATS_EN
    ,
    output logic [15:0]       stat_retired,
    output logic [15:0]       stat_taken
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_STEER = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [8:0] HALT_INST = 9'b101_111111;

    state_t        state_reg, state_next;
    logic [IW-1:0] inst_reg;
    logic          zf_reg;
    logic [1:0]    steer_type;
    logic          is_halt;

    // State register; reset drops any in-flight fetch or handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Capture the fetched instruction; it stays stable through ISSUE and STEER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              inst_reg <= '0;
        else if (state_reg == S_FETCH && imem_valid) inst_reg <= imem_data;
    end

    // Sample the zero flag on the handshake edge; it steers BZ in STEER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  zf_reg <= 1'b0;
        else if (state_reg == S_ISSUE && inst_ready) zf_reg <= zero_flag;
    end

    // Branch decode from the registered instruction and sampled zero flag.
    always_comb begin
        steer_type = 2'b00;
        is_halt    = (inst_reg[8:0] == HALT_INST);
        case (inst_reg[8:6])
            3'b110:  steer_type = zf_reg ? 2'b01 : 2'b00;
            3'b111:  steer_type = 2'b10;
            default: steer_type = 2'b00;
        endcase
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        state_next = state_reg;
        pc_rst     = 1'b0;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;
        branchType = 2'b11;
        case (state_reg)
            S_IDLE: begin
                pc_rst = 1'b1;
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                inst_valid = 1'b1;
                if (inst_ready) state_next = is_halt ? S_HALT : S_STEER;
            end
            S_STEER: begin
                branchType = steer_type;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign imem_addr      = imem_req ? p_ct : '0;
    assign inst           = inst_reg;
    assign threeBitOffset = inst_reg[2:0];
    assign sixBitOffset   = inst_reg[5:0];

`ifdef FETCH_STEER_STATS_EN
    logic [15:0] retired_reg, taken_reg;
    logic        enter_idle, taken_now;

    assign enter_idle = (state_next == S_IDLE) && (state_reg != S_IDLE);
    assign taken_now  = (branchType == 2'b01) || (branchType == 2'b10);

    // Saturating retire/taken counters, cleared whenever the controller re-enters IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_reg <= '0;
            taken_reg   <= '0;
        end else if (enter_idle) begin
            retired_reg <= '0;
            taken_reg   <= '0;
        end else if (state_reg == S_STEER) begin
            if (retired_reg != 16'hFFFF)            retired_reg <= retired_reg + 16'd1;
            if (taken_now && taken_reg != 16'hFFFF) taken_reg   <= taken_reg + 16'd1;
        end
    end

    assign stat_retired = retired_reg;
    assign stat_taken   = taken_reg;
`endif

endmodule

// File: tb/tb_fetch_steer.sv
// tb_fetch_steer: randomized bench for fetch_steer with an instruction-level
// reference model (expected PC, branch type, offsets and per-state timing).
// Honours FETCH_STEER_STATS_EN for the optional counters.
module tb_fetch_steer;

    localparam int IW = 9;
    localparam int AW = 10;
    localparam logic [8:0] HALT_I = 9'b101_111111;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     p_ct = '0;
    logic              pc_rst, imem_req, inst_valid, halted;
    logic [AW-1:0]     imem_addr;
    logic              imem_valid = 1'b0;
    logic [IW-1:0]     imem_data = '0;
    logic [IW-1:0]     inst;
    logic              inst_ready = 1'b0;
    logic              zero_flag = 1'b0;
    logic [1:0]        branchType;
    logic signed [2:0] threeBitOffset;
    logic signed [5:0] sixBitOffset;
`ifdef FETCH_STEER_STATS_EN
    logic [15:0]       stat_retired, stat_taken;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int pc_m  = 0;
    int ret_m = 0;
    int tak_m = 0;

    fetch_steer #(.IW(IW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .p_ct(p_ct),
        .pc_rst(pc_rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data), .inst(inst),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .zero_flag(zero_flag),
        .branchType(branchType), .threeBitOffset(threeBitOffset),
        .sixBitOffset(sixBitOffset), .halted(halted)
`ifdef FETCH_STEER_STATS_EN
        , .stat_retired(stat_retired), .stat_taken(stat_taken)
`endif
    );

    always #5 clk = ~clk;

    // Program counter model driven by the controller's outputs.
    always @(posedge clk) begin
        if (pc_rst) p_ct <= '0;
        else case (branchType)
            2'b00: p_ct <= p_ct + 10'd1;
            2'b01: p_ct <= p_ct + {{7{threeBitOffset[2]}}, threeBitOffset};
            2'b10: p_ct <= p_ct + {{4{sixBitOffset[5]}}, sixBitOffset};
            default: p_ct <= p_ct;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_stats;
`ifdef FETCH_STEER_STATS_EN
        check("stat_retired", 32'(stat_retired), 32'(ret_m));
        check("stat_taken", 32'(stat_taken), 32'(tak_m));
`endif
    endtask

    task automatic check_idle(input string where);
        check({where, "_pc_rst"}, 32'(pc_rst), 32'd1);
        check({where, "_bt"}, 32'(branchType), 32'd3);
        check({where, "_req"}, 32'(imem_req), 32'd0);
        check({where, "_addr"}, 32'(imem_addr), 32'd0);
        check({where, "_ivalid"}, 32'(inst_valid), 32'd0);
        check({where, "_halted"}, 32'(halted), 32'd0);
    endtask

    // From IDLE at a negedge: pulse start and land at the first FETCH.
    task automatic launch;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        pc_m  = 0;
        ret_m = 0;
        tak_m = 0;
    endtask

    // One instruction from FETCH onward. dv/dr are stall cycles before
    // imem_valid and inst_ready; zf is the zero flag at the handshake.
    task automatic run_inst(input logic [8:0] ins, input int dv, input int dr,
                            input logic zf, input bit rst_issue);
        int bt_e, nxt, s3, s6;
        for (int c = 0; c <= dv; c++) begin
            check("fetch_req", 32'(imem_req), 32'd1);
            check("fetch_addr", 32'(imem_addr), 32'(pc_m));
            check("fetch_bt", 32'(branchType), 32'd3);
            check("fetch_ivalid", 32'(inst_valid), 32'd0);
            imem_valid = (c == dv);
            imem_data  = (c == dv) ? ins : 9'($urandom);
            inst_ready = 1'($urandom);
            zero_flag  = 1'($urandom);
            start      = 1'($urandom);
            @(posedge clk); @(negedge clk);
        end
        for (int c = 0; c <= dr; c++) begin
            check("issue_ivalid", 32'(inst_valid), 32'd1);
            check("issue_inst", 32'(inst), 32'(ins));
            check("issue_bt", 32'(branchType), 32'd3);
            check("issue_req", 32'(imem_req), 32'd0);
            if (rst_issue) begin
                #2 reset = 1'b0;
                #1;
                check_idle("arst");
                check("arst_inst", 32'(inst), 32'd0);
                check("arst_off3", {29'd0, threeBitOffset}, 32'd0);
                check("arst_off6", {26'd0, sixBitOffset}, 32'd0);
                ret_m = 0;
                tak_m = 0;
                check_stats();
                return;
            end
            inst_ready = (c == dr);
            zero_flag  = (c == dr) ? zf : 1'($urandom);
            imem_valid = 1'($urandom);
            imem_data  = 9'($urandom);
            start      = (c == dr) ? 1'b0 : 1'($urandom);
            @(posedge clk); @(negedge clk);
        end
        inst_ready = 1'b0;
        if (ins == HALT_I) begin
            for (int c = 0; c < 4; c++) begin
                check("halt_halted", 32'(halted), 32'd1);
                check("halt_bt", 32'(branchType), 32'd3);
                check("halt_req", 32'(imem_req), 32'd0);
                @(posedge clk); @(negedge clk);
            end
            start = 1'b1;
            @(posedge clk); @(negedge clk);
            ret_m = 0;
            tak_m = 0;
            check_idle("restart");
            check_stats();
            launch();
            return;
        end
        s3 = ins[2] ? int'(ins[2:0]) - 8 : int'(ins[2:0]);
        s6 = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
        if (ins[8:6] == 3'b110 && zf) begin bt_e = 1; nxt = pc_m + s3; end
        else if (ins[8:6] == 3'b111)  begin bt_e = 2; nxt = pc_m + s6; end
        else                          begin bt_e = 0; nxt = pc_m + 1;  end
        check("steer_bt", 32'(branchType), 32'(bt_e));
        check("steer_off3", {29'd0, threeBitOffset}, {29'd0, ins[2:0]});
        check("steer_off6", {26'd0, sixBitOffset}, {26'd0, ins[5:0]});
        check("steer_ivalid", 32'(inst_valid), 32'd0);
        start      = 1'($urandom);
        imem_valid = 1'($urandom);
        @(posedge clk); @(negedge clk);
        pc_m = ((nxt % 1024) + 1024) % 1024;
        ret_m++;
        if (bt_e != 0) tak_m++;
        check_stats();
    endtask

    initial begin
        logic [8:0] r;
        @(negedge clk); @(negedge clk);
        check_idle("rst");
        check("rst_inst", 32'(inst), 32'd0);
        check_stats();
        reset = 1'b1;
        @(negedge clk);
        check_idle("idle");
        launch();

        // Reset/start cadence, wrap jump, conditional branch both ways, stalls.
        run_inst(9'b000_000_000, 0, 0, 1'b0, 1'b0);
        run_inst(9'b000_000_000, 0, 0, 1'b0, 1'b0);
        check("pc_is_2", 32'(pc_m), 32'd2);
        run_inst(9'b111_111100, 0, 0, 1'b0, 1'b0);
        check("wrap_1022", 32'(pc_m), 32'd1022);
        run_inst(9'b110_000_011, 0, 0, 1'b1, 1'b0);
        run_inst(9'b110_000_011, 0, 0, 1'b0, 1'b0);
        run_inst(9'b000_101_010, 4, 3, 1'b0, 1'b0);

        // Random program, including occasional HALTs and restarts.
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0) ? HALT_I : 9'($urandom);
            run_inst(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b0);
        end

        run_inst(HALT_I, 1, 1, 1'b0, 1'b0);
        run_inst(9'b110_000_111, 0, 0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of ISSUE.
        run_inst(9'b111_000_001, 1, 2, 1'b1, 1'b1);
        @(negedge clk);
        check_idle("post_arst");
        reset = 1'b1;
        @(negedge clk);
        launch();
        run_inst(9'b000_000_001, 0, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_steer.md
# fetch_steer

Instruction-fetch and branch-steering controller paired with the program counter. Reads the current `p_ct`, fetches a 9-bit instruction from instruction memory, and hands it to the datapath over a valid/ready handshake. It then decodes the branch fields and drives `branchType`, `threeBitOffset` and `sixBitOffset` back into the PC for exactly one cycle per instruction. At all other times it holds `branchType = 2'b11`, which the PC treats as "hold".

## Interface
- `IW`, 9, instruction width
- `AW`, 10, instruction address width; matches `p_ct`

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  level; leaves IDLE or HALT
- `p_ct`  in  AW  current PC value
- `pc_rst`  out  1  synchronous reset to PC; asserted while in IDLE
- `imem_req`  out  1  fetch request; high throughout FETCH
- `imem_addr`  out  AW  equals `p_ct` while `imem_req` is high, else 0
- `imem_valid`  in  1  `imem_data` is valid this cycle
- `imem_data`  in  IW  fetched instruction
- `inst`  out  IW  instruction to datapath; registered
- `inst_valid`  out  1  high throughout ISSUE
- `inst_ready`  in  1  datapath accepts `inst`
- `zero_flag`  in  1  datapath zero flag
- `branchType`  out  2  00 = +1, 01 = +threeBitOffset, 10 = +sixBitOffset, 11 = hold
- `threeBitOffset`  out  3 signed  equals `inst[2:0]`
- `sixBitOffset`  out  6 signed  equals `inst[5:0]`
- `halted`  out  1  high in HALT

## Operation
- States: IDLE, FETCH, ISSUE, STEER, HALT.
- IDLE:
  - `pc_rst = 1`, `branchType = 11`.
  - `start = 1` → FETCH.
- FETCH:
  - `imem_req = 1`.
  - On a cycle with `imem_valid = 1`, capture `imem_data` into `inst` and go to ISSUE.
  - `imem_valid` is ignored in every other state.
- ISSUE:
  - `inst_valid = 1` and `inst` is held stable until `inst_ready = 1`.
  - On the handshake edge, sample `zero_flag` into `zf_q`, compute the steer decision, and go to STEER.
- Decode, taken from `inst`:
  - `inst[8:6] = 110` (BZ): `branchType = 01` if `zf_q`, else `00`.
  - `inst[8:6] = 111` (JMP): `branchType = 10`, unconditional.
  - `inst = 9'b101_111111` (HALT): go to HALT; no PC update.
  - Anything else: `00`.
- STEER:
  - The decoded `branchType` is driven for exactly one cycle; the PC updates on that edge.
  - Next state is FETCH.
- HALT:
  - `branchType = 11`, `halted = 1`.
  - `start = 1` → IDLE.
- All instructions, including branches and HALT, pass through ISSUE. The datapath treats branch and HALT encodings as no-ops.
- Offset outputs are combinational slices of registered `inst`. The PC sign-extends them; offset arithmetic wraps modulo 2^AW.

## Timing
- Reset values, applied asynchronously on `reset = 0`:
  - State = IDLE, `inst = 0`, `zf_q = 0`, `inst_valid = 0`, `imem_req = 0`, `halted = 0`.
  - `branchType = 11`, `pc_rst = 1`, offsets = 0.
- Minimum of 3 cycles per instruction (FETCH, ISSUE, STEER) when `imem_valid` and `inst_ready` are both high on the first cycle of their state.
- `imem_addr` is sampled in FETCH. `p_ct` is stable there because the PC last moved on the previous STEER edge.
- `start` is ignored in FETCH, ISSUE and STEER.
- The first FETCH after IDLE sees `p_ct = 0`, because `pc_rst` was asserted on the preceding edge.
- Reset deassertion mid-operation returns to IDLE; any in-flight fetch or handshake is dropped.
- `inst_ready` arriving before ISSUE is ignored. `inst_valid` never drops without a handshake, except on reset.
- Branch at address 0 with a negative offset wraps; for example, 0 + (−2) = 1022 with AW = 10.

## Configuration
- Macro: `FETCH_STEER_STATS_EN`.
- Defined: adds two 16-bit saturating counters with outputs `stat_retired` and `stat_taken`.
  - `stat_retired` increments on every STEER cycle.
  - `stat_taken` increments on STEER cycles where `branchType` is 01 or 10.
  - Both counters clear on reset and on entry to IDLE, and stick at 0xFFFF.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Test plan
- Reset and start:
  - Stimulus: assert `reset = 0`, then release, then `start = 1`, with `imem_valid = inst_ready = 1` always.
  - Required: `pc_rst = 1` in IDLE; first `imem_addr = 0`; `branchType` sequence is 11, 11, 00 at 3-cycle cadence.
- Conditional branch:
  - Stimulus: `inst = 9'b110_000_011` with `zero_flag = 1` at the handshake.
  - Required: `branchType = 01`, `threeBitOffset = +3` for one cycle; next `imem_addr` = old + 3.
  - Repeat with `zero_flag = 0`: required `branchType = 00`, next `imem_addr` = old + 1.
- Backward jump with wrap:
  - Stimulus: at `p_ct = 2`, `inst = 9'b111_111100`.
  - Required: `branchType = 10`, `sixBitOffset = −4`, next `imem_addr = 1022`.
- Handshake stalls:
  - Stimulus: delay `imem_valid` by 4 cycles and `inst_ready` by 3 cycles.
  - Required: `imem_req` stays high for 5 cycles; `inst` is stable and `inst_valid` high for 4 cycles; `branchType` stays 11 throughout; per-instruction latency = 10 cycles.
- HALT and restart:
  - Stimulus: `inst = 9'b101_111111`.
  - Required: `halted = 1`, `branchType` stays 11 indefinitely.
  - Then `start = 1`: required IDLE, then `pc_rst`, then fetch from address 0.
- Async reset mid-ISSUE with `FETCH_STEER_STATS_EN` defined:
  - Required: outputs reach their reset values within the same cycle.
  - Required: `stat_retired = stat_taken = 0`.
